// File: rtl/debounce_pkg.sv
// Shared types, parameter limits and helpers for the debounced bit monitor.
// Imported by the top level and the event FIFO.
package debounce_pkg;

  typedef enum logic {
    EVT_FALL = 1'b0,
    EVT_RISE = 1'b1
  } evt_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MIN    = 1;
  localparam int DEBOUNCE_MAX    = 65535;
  localparam int EVT_DEPTH_MIN   = 2;

  // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter never wraps.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/bit_event_fifo.sv
// Circular buffer of 1-bit edge events with wrap-bit pointers.
// A push into a full buffer is accepted only when a pop frees a slot on the same edge.
module bit_event_fifo
  import debounce_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  evt_t i_push_evt,
  input  logic i_pop,
  output logic o_valid,
  output evt_t o_head_evt,
  output logic o_drop
);

  localparam int AW = $clog2(DEPTH);

  evt_t       r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop_ok;
  logic        w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_drop    = i_push && w_full && !w_pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_evt;
  end

  assign o_valid    = !w_empty;
  assign o_head_evt = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/debounced_bit_monitor.sv
// Synchronises and debounces an asynchronous level, emits RISE/FALL pulses and
// queues each debounced edge in a small event FIFO drained over valid/ready.
module debounced_bit_monitor
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b1,
  parameter int EVT_DEPTH       = 4
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  input  logic I,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic EVT_VALID,
  input  logic EVT_READY,
  output logic EVT_DATA,
  output logic OVERFLOW,
  input  logic CLR_OVF
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("debounced_bit_monitor: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_debounce
    $error("debounced_bit_monitor: DEBOUNCE_CYCLES must be 1..65535");
  end
  if (EVT_DEPTH < EVT_DEPTH_MIN || !is_pow2(EVT_DEPTH)) begin : g_bad_depth
    $error("debounced_bit_monitor: EVT_DEPTH must be a power of two >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_o;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_ovf;
  logic                   w_s;
  logic                   w_mismatch;
  logic                   w_toggle;
  logic                   w_pop;
  logic                   w_drop;
  evt_t                   w_push_evt;
  evt_t                   w_head_evt;

  // NOTE: non-blocking assignments make every stage sample its neighbour's pre-edge value.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    else              r_sync <= {r_sync[SYNC_STAGES-2:0], I};
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_s != r_o);
  assign w_toggle   = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_o    <= RESET_LEVEL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_toggle && w_s;
      r_fall <= w_toggle && !w_s;
      if (!w_mismatch || w_toggle) r_cnt <= '0;
      else                         r_cnt <= r_cnt + CW'(1);
      if (w_toggle) r_o <= w_s;
    end
  end

  // A drop on the same edge as a clear wins, so no lost event goes unreported.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)  r_ovf <= 1'b0;
    else if (w_drop)   r_ovf <= 1'b1;
    else if (CLR_OVF)  r_ovf <= 1'b0;
  end

  assign w_push_evt = w_s ? EVT_RISE : EVT_FALL;
  assign w_pop      = EVT_VALID && EVT_READY;

  bit_event_fifo #(
    .DEPTH(EVT_DEPTH)
  ) u_evt_fifo (
    .clk        (CLK),
    .rst_n      (ASYNCRESETN),
    .i_push     (w_toggle),
    .i_push_evt (w_push_evt),
    .i_pop      (w_pop),
    .o_valid    (EVT_VALID),
    .o_head_evt (w_head_evt),
    .o_drop     (w_drop)
  );

  assign O        = r_o;
  assign RISE     = r_rise;
  assign FALL     = r_fall;
  assign EVT_DATA = w_head_evt;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_debounced_bit_monitor.sv
// Directed and randomized checks of debounced_bit_monitor against a behavioural
// model built from sampled-input history and an event queue.
module tb_debounced_bit_monitor;

  localparam int SS    = 2;
  localparam int DC    = 16;
  localparam int DEPTH = 4;
  localparam bit RL    = 1'b1;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  logic I = 1'b1;
  logic EVT_READY = 1'b0;
  logic CLR_OVF = 1'b0;
  logic O, RISE, FALL, EVT_VALID, EVT_DATA, OVERFLOW;

  debounced_bit_monitor #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (RL),
    .EVT_DEPTH      (DEPTH)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I          (I),
    .O          (O),
    .RISE       (RISE),
    .FALL       (FALL),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_DATA   (EVT_DATA),
    .OVERFLOW   (OVERFLOW),
    .CLR_OVF    (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: I as sampled at each edge, s values seen, queued events.
  bit m_ihist [$];
  bit m_swin  [$];
  bit m_q     [$];
  bit m_o, m_rise, m_fall, m_ovf;

  int   n_rise_seen, n_fall_seen, n_o_changes;
  logic prev_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ihist.delete();
    m_swin.delete();
    m_q.delete();
    repeat (SS) m_ihist.push_back(RL);
    m_o    = RL;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // New level is taken once s has differed from O on the last DC edges.
  task automatic model_edge();
    bit s, toggled, pop, full, drop;
    s = m_ihist.pop_front();
    m_ihist.push_back(I);
    m_swin.push_back(s);
    if (m_swin.size() > DC) void'(m_swin.pop_front());
    toggled = (m_swin.size() == DC);
    foreach (m_swin[k]) if (m_swin[k] == m_o) toggled = 1'b0;
    pop  = (m_q.size() > 0) && EVT_READY;
    full = (m_q.size() == DEPTH);
    drop = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (toggled) begin
      m_o = s;
      if (!full || pop) m_q.push_back(m_o);
      else              drop = 1'b1;
    end
    m_rise = toggled && m_o;
    m_fall = toggled && !m_o;
    if (drop)         m_ovf = 1'b1;
    else if (CLR_OVF) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    check("o", O, m_o);
    check("rise", RISE, m_rise);
    check("fall", FALL, m_fall);
    check("evt_valid", EVT_VALID, m_q.size() > 0);
    if (m_q.size() > 0) check("evt_data", EVT_DATA, m_q[0]);
    check("overflow", OVERFLOW, m_ovf);
  endtask

  task automatic clear_counts();
    n_rise_seen = 0;
    n_fall_seen = 0;
    n_o_changes = 0;
    prev_o      = O;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
    if (RISE === 1'b1) n_rise_seen++;
    if (FALL === 1'b1) n_fall_seen++;
    if (O !== prev_o) n_o_changes++;
    prev_o = O;
  endtask

  task automatic toggles(input int n, input int hold);
    repeat (n) begin
      I = ~I;
      repeat (hold) cycle();
    end
  endtask

  task automatic drain(input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      check("drain_valid", EVT_VALID, 1'b1);
      check("drain_data", EVT_DATA, exp[i]);
      EVT_READY = 1'b1;
      cycle();
    end
    EVT_READY = 1'b0;
    check("drain_empty", EVT_VALID, 1'b0);
  endtask

  initial begin
    int first_low;
    int hold;
    model_reset();
    @(negedge CLK);
    compare_all();
    ASYNCRESETN = 1'b1;
    clear_counts();

    // Idle high after reset.
    repeat (40) cycle();
    check("t1_o", O, 1'b1);
    check("t1_rise", RISE, 1'b0);
    check("t1_fall", FALL, 1'b0);
    check("t1_evt_valid", EVT_VALID, 1'b0);
    check("t1_overflow", OVERFLOW, 1'b0);

    // Clean falling step: O follows at edge 18.
    clear_counts();
    first_low = -1;
    I = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (first_low < 0 && O === 1'b0) first_low = k;
    end
    check("t2_latency", first_low, 18);
    check("t2_fall_pulses", n_fall_seen, 1);
    check("t2_evt_valid", EVT_VALID, 1'b1);
    check("t2_evt_data", EVT_DATA, 1'b0);
    drain(1, 8'b0000_0000);
    I = 1'b1;
    repeat (40) cycle();
    drain(1, 8'b0000_0001);

    // Glitch filtering: 15 sampled cycles rejected, 16 accepted.
    clear_counts();
    I = 1'b0;
    repeat (15) cycle();
    I = 1'b1;
    repeat (40) cycle();
    check("t3_glitch15_o_changes", n_o_changes, 0);
    check("t3_glitch15_valid", EVT_VALID, 1'b0);
    clear_counts();
    I = 1'b0;
    repeat (16) cycle();
    I = 1'b1;
    repeat (40) cycle();
    check("t3_pulse16_o_changes", n_o_changes, 2);
    drain(2, 8'b0000_0010);

    // Overflow: five events into four slots.
    toggles(5, 25);
    check("t4_overflow", OVERFLOW, 1'b1);
    drain(4, 8'b0000_1010);
    CLR_OVF = 1'b1;
    cycle();
    CLR_OVF = 1'b0;
    check("t4_ovf_cleared", OVERFLOW, 1'b0);

    // Full buffer, push coinciding with pop: nothing dropped.
    toggles(4, 25);
    check("t5_full_no_ovf", OVERFLOW, 1'b0);
    I = 1'b1;
    repeat (SS + DC - 1) cycle();
    EVT_READY = 1'b1;
    cycle();
    EVT_READY = 1'b0;
    check("t5_o", O, 1'b1);
    check("t5_overflow", OVERFLOW, 1'b0);
    drain(4, 8'b0000_1010);

    // Reset in the middle of a debounce with O low and OVERFLOW set.
    toggles(5, 25);
    check("t6_pre_overflow", OVERFLOW, 1'b1);
    I = 1'b1;
    repeat (12) cycle();
    check("t6_pre_o", O, 1'b0);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("t6_rst_o", O, 1'b1);
    check("t6_rst_valid", EVT_VALID, 1'b0);
    check("t6_rst_overflow", OVERFLOW, 1'b0);
    check("t6_rst_rise", RISE, 1'b0);
    model_reset();
    @(negedge CLK);
    compare_all();
    ASYNCRESETN = 1'b1;
    clear_counts();
    repeat (30) cycle();
    check("t6_no_rise", n_rise_seen, 0);

    // Randomized level runs, backpressure and overflow clears.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        I    = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 30));
      end
      hold--;
      if (c < 1500) EVT_READY = ($urandom_range(0, 3) == 0);
      else          EVT_READY = ($urandom_range(0, 3) != 0);
      CLR_OVF = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
